// File: rtl/xil_7s_dphy_hs_data_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : xil_7s_dphy_hs_data_tx_ctrl_if
// Description : Payload stream and lane-driver bundle for the D-PHY HS data
//               lane transmit sequencer. burst_cnt_o exists only when
//               XIL_7S_DPHY_TX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface xil_7s_dphy_hs_data_tx_ctrl_if;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_last_i;
  logic        tx_ready_o;
  logic [7:0]  hs_data_o;
  logic        hs_oe_o;
  logic        lp_p_o;
  logic        lp_n_o;
  logic        busy_o;
  logic        underrun_o;
`ifdef XIL_7S_DPHY_TX_STATS_EN
  logic [15:0] burst_cnt_o;
`endif

  // Sequencer side: consumes the payload stream, drives the lane
  modport slave (
    input  tx_data_i, tx_valid_i, tx_last_i,
    output tx_ready_o, hs_data_o, hs_oe_o, lp_p_o, lp_n_o, busy_o, underrun_o
`ifdef XIL_7S_DPHY_TX_STATS_EN
    , output burst_cnt_o
`endif
  );

  // Source side: produces payload bytes, observes the lane
  modport master (
    output tx_data_i, tx_valid_i, tx_last_i,
    input  tx_ready_o, hs_data_o, hs_oe_o, lp_p_o, lp_n_o, busy_o, underrun_o
`ifdef XIL_7S_DPHY_TX_STATS_EN
    , input burst_cnt_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/xil_7s_dphy_hs_data_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xil_7s_dphy_hs_data_tx_ctrl
// Description : Byte-clock transmit sequencer for one MIPI D-PHY data lane.
//               Drives LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync 0xB8 ->
//               payload -> HS-trail -> LP-11 for each packet taken from a
//               valid/ready byte stream.
//               Optional macro XIL_7S_DPHY_TX_STATS_EN adds burst_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module xil_7s_dphy_hs_data_tx_ctrl #(
  parameter int LPX_CYCLES        = 4,
  parameter int HS_PREPARE_CYCLES = 2,
  parameter int HS_ZERO_CYCLES    = 8,
  parameter int HS_TRAIL_CYCLES   = 4,
  parameter int HS_EXIT_CYCLES    = 6
) (
  input  logic                                byte_clk_i,
  input  logic                                rst_i,
  xil_7s_dphy_hs_data_tx_ctrl_if.slave        tx_bus
);

  // Zero-length phases are stretched to one cycle
  localparam int LPX_N   = (LPX_CYCLES        < 1) ? 1 : LPX_CYCLES;
  localparam int PREP_N  = (HS_PREPARE_CYCLES < 1) ? 1 : HS_PREPARE_CYCLES;
  localparam int ZERO_N  = (HS_ZERO_CYCLES    < 1) ? 1 : HS_ZERO_CYCLES;
  localparam int TRAIL_N = (HS_TRAIL_CYCLES   < 1) ? 1 : HS_TRAIL_CYCLES;
  localparam int EXIT_N  = (HS_EXIT_CYCLES    < 1) ? 1 : HS_EXIT_CYCLES;

  localparam int MAX_A   = (LPX_N  > PREP_N)  ? LPX_N  : PREP_N;
  localparam int MAX_B   = (ZERO_N > TRAIL_N) ? ZERO_N : TRAIL_N;
  localparam int MAX_AB  = (MAX_A  > MAX_B)   ? MAX_A  : MAX_B;
  localparam int MAX_N   = (MAX_AB > EXIT_N)  ? MAX_AB : EXIT_N;
  localparam int CW      = $clog2(MAX_N + 1);

  // Phase counters count down from length-1 to 0
  localparam logic [CW-1:0] LPX_LOAD   = CW'(LPX_N - 1);
  localparam logic [CW-1:0] PREP_LOAD  = CW'(PREP_N - 1);
  localparam logic [CW-1:0] ZERO_LOAD  = CW'(ZERO_N - 1);
  localparam logic [CW-1:0] TRAIL_LOAD = CW'(TRAIL_N - 1);
  localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_N - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LP_RQST  = 4'd1,
    LP_BRDG  = 4'd2,
    HS_ZERO  = 4'd3,
    HS_SYNC  = 4'd4,
    HS_DATA  = 4'd5,
    HS_TRAIL = 4'd6,
    HS_EXIT  = 4'd7
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_shown, last_nxt;
  logic [7:0]    hs_data, hs_data_nxt, pay_nxt;
  logic          hs_oe, hs_oe_nxt;
  logic          lp_p, lp_p_nxt;
  logic          lp_n, lp_n_nxt;
  logic          busy, busy_nxt;
  logic          underrun, underrun_nxt;
  logic          ready;

  // The sink can take a byte in the sync cycle and in every payload cycle
  // except the one showing the packet's final byte
  assign ready = (state == HS_SYNC) || ((state == HS_DATA) && !last_shown);

  assign tx_bus.tx_ready_o = ready;
  assign tx_bus.hs_data_o  = hs_data;
  assign tx_bus.hs_oe_o    = hs_oe;
  assign tx_bus.lp_p_o     = lp_p;
  assign tx_bus.lp_n_o     = lp_n;
  assign tx_bus.busy_o     = busy;
  assign tx_bus.underrun_o = underrun;

  // Next-state sequencing plus decode of the registered lane outputs
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last_shown;
    pay_nxt      = hs_data;
    underrun_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (tx_bus.tx_valid_i) begin
          state_nxt = LP_RQST;
          cnt_nxt   = LPX_LOAD;
        end
      end
      LP_RQST: begin
        if (cnt == '0) begin
          state_nxt = LP_BRDG;
          cnt_nxt   = PREP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      LP_BRDG: begin
        if (cnt == '0) begin
          state_nxt = HS_ZERO;
          cnt_nxt   = ZERO_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HS_ZERO: begin
        if (cnt == '0) begin
          state_nxt = HS_SYNC;
          last_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HS_SYNC, HS_DATA: begin
        if (ready && tx_bus.tx_valid_i) begin
          state_nxt = HS_DATA;
          pay_nxt   = tx_bus.tx_data_i;
          last_nxt  = tx_bus.tx_last_i;
        end else begin
          // Either the final byte has been shown or the source starved us;
          // trail is the inverse of the last bit sent (0xB8 in sync)
          state_nxt    = HS_TRAIL;
          cnt_nxt      = TRAIL_LOAD;
          pay_nxt      = {8{~hs_data[7]}};
          underrun_nxt = ready;
        end
      end
      HS_TRAIL: begin
        if (cnt == '0) begin
          state_nxt = HS_EXIT;
          cnt_nxt   = EXIT_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HS_EXIT: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    hs_data_nxt = 8'h00;
    hs_oe_nxt   = 1'b0;
    lp_p_nxt    = 1'b0;
    lp_n_nxt    = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      IDLE, HS_EXIT: begin
        lp_p_nxt = 1'b1;
        lp_n_nxt = 1'b1;
      end
      LP_RQST: begin
        lp_n_nxt = 1'b1;
      end
      HS_ZERO: begin
        hs_oe_nxt = 1'b1;
      end
      HS_SYNC: begin
        hs_oe_nxt   = 1'b1;
        hs_data_nxt = SYNC_BYTE;
      end
      HS_DATA, HS_TRAIL: begin
        hs_oe_nxt   = 1'b1;
        hs_data_nxt = pay_nxt;
      end
      default: begin
        hs_data_nxt = 8'h00;
      end
    endcase
  end

`ifdef XIL_7S_DPHY_TX_STATS_EN
  logic [15:0] burst_cnt;
  assign tx_bus.burst_cnt_o = burst_cnt;

  // Completed-burst counter, bumped on each return from HS_EXIT to IDLE
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      burst_cnt <= 16'h0000;
    end else if ((state == HS_EXIT) && (state_nxt == IDLE)) begin
      burst_cnt <= burst_cnt + 16'h0001;
    end
  end
`endif

  // State, phase counter and lane outputs all update on the same edge
  always_ff @(posedge byte_clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      last_shown <= 1'b0;
      hs_data    <= 8'h00;
      hs_oe      <= 1'b0;
      lp_p       <= 1'b1;
      lp_n       <= 1'b1;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_shown <= last_nxt;
      hs_data    <= hs_data_nxt;
      hs_oe      <= hs_oe_nxt;
      lp_p       <= lp_p_nxt;
      lp_n       <= lp_n_nxt;
      busy       <= busy_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xil_7s_dphy_hs_data_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xil_7s_dphy_hs_data_tx_ctrl
// Description : Vector-table bench for the D-PHY HS data lane sequencer, plus
//               hand-written burst-length / underrun sequences.
//               Burst counter checks compile in with XIL_7S_DPHY_TX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xil_7s_dphy_hs_data_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xil_7s_dphy_hs_data_tx_ctrl_if tx_bus ();

  xil_7s_dphy_hs_data_tx_ctrl dut (
    .byte_clk_i (clk),
    .rst_i      (rst),
    .tx_bus     (tx_bus)
  );

  always #5 clk = ~clk;

  // Row: inputs applied for one cycle, expected outputs after the next edge.
  // exp = {ready, hs_data[7:0], hs_oe, lp_p, lp_n, busy, underrun}
  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [13:0] e_idle();  return {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; endfunction
  function automatic logic [13:0] e_rqst();  return {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; endfunction
  function automatic logic [13:0] e_brdg();  return {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; endfunction
  function automatic logic [13:0] e_zero();  return {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; endfunction
  function automatic logic [13:0] e_sync();  return {1'b1, 8'hB8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; endfunction
  function automatic logic [13:0] e_exit();  return {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; endfunction
  function automatic logic [13:0] e_data(input logic [7:0] d, input logic rdy);
    return {rdy, d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  endfunction
  function automatic logic [13:0] e_trail(input logic [7:0] d, input logic und);
    return {1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1, und};
  endfunction

  function automatic void push(input logic r, input logic v, input logic [7:0] d,
                               input logic l, input logic [13:0] e);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.last = l; x.exp = e;
    vecs.push_back(x);
  endfunction

  // IDLE-exit row followed by LP-01 x4, LP-00 x2, HS-zero x8, sync x1
  function automatic void add_pre(input logic [7:0] d, input logic l);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, d, l, e_rqst());
    for (int i = 0; i < 2; i++) push(1'b0, 1'b1, d, l, e_brdg());
    for (int i = 0; i < 8; i++) push(1'b0, 1'b1, d, l, e_zero());
    push(1'b0, 1'b1, d, l, e_sync());
  endfunction

  function automatic void add_exit_idle(input logic v, input logic [7:0] d, input logic l);
    for (int i = 0; i < 6; i++) push(1'b0, v, d, l, e_exit());
    push(1'b0, v, d, l, e_idle());
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%04h expected 0x%04h", name, idx, act, exp);
    end
  endtask

  // Present one byte, drop valid once it is accepted, run until busy falls
  task automatic run_burst(input logic [7:0] d, input logic l,
                           output int busy_cyc, output int und_cyc, output logic timeout);
    logic acc;
    busy_cyc = 0;
    und_cyc  = 0;
    timeout  = 1'b1;
    tx_bus.tx_valid_i = 1'b1;
    tx_bus.tx_data_i  = d;
    tx_bus.tx_last_i  = l;
    for (int i = 0; i < 100; i++) begin
      acc = tx_bus.tx_ready_o & tx_bus.tx_valid_i;
      tick();
      if (acc) tx_bus.tx_valid_i = 1'b0;
      if (tx_bus.busy_o) busy_cyc++;
      if (tx_bus.underrun_o) und_cyc++;
      if (!tx_bus.busy_o && busy_cyc > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    tx_bus.tx_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bc, uc;
    logic to;
    logic [13:0] act;

    tx_bus.tx_valid_i = 1'b0;
    tx_bus.tx_data_i  = 8'h00;
    tx_bus.tx_last_i  = 1'b0;

    // Single byte 0x5A, last
    push(1'b1, 1'b0, 8'h00, 1'b0, e_idle());
    add_pre(8'h5A, 1'b1);
    push(1'b0, 1'b1, 8'h5A, 1'b1, e_data(8'h5A, 1'b0));
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b0));
    add_exit_idle(1'b0, 8'h00, 1'b0);

    // Back-to-back 01,02,03,84; trail follows bit 7 of 0x84
    add_pre(8'h01, 1'b0);
    push(1'b0, 1'b1, 8'h01, 1'b0, e_data(8'h01, 1'b1));
    push(1'b0, 1'b1, 8'h02, 1'b0, e_data(8'h02, 1'b1));
    push(1'b0, 1'b1, 8'h03, 1'b0, e_data(8'h03, 1'b1));
    push(1'b0, 1'b1, 8'h84, 1'b1, e_data(8'h84, 1'b0));
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'h00, 1'b0));
    add_exit_idle(1'b0, 8'h00, 1'b0);

    // Underrun after 0x11; 0x22 held valid through trail/exit, one IDLE cycle
    add_pre(8'h11, 1'b0);
    push(1'b0, 1'b1, 8'h11, 1'b0, e_data(8'h11, 1'b1));
    push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b1));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 8'h22, 1'b1, e_trail(8'hFF, 1'b0));
    add_exit_idle(1'b1, 8'h22, 1'b1);
    add_pre(8'h22, 1'b1);
    push(1'b0, 1'b1, 8'h22, 1'b1, e_data(8'h22, 1'b0));
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b0));
    add_exit_idle(1'b0, 8'h00, 1'b0);

    // Underrun in the sync cycle: trail derives from 0xB8 -> 0x00
    add_pre(8'h33, 1'b0);
    push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'h00, 1'b1));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'h00, 1'b0));
    add_exit_idle(1'b0, 8'h00, 1'b0);

    // Reset while the second of four bytes is on the lane, then a clean burst
    add_pre(8'h10, 1'b0);
    push(1'b0, 1'b1, 8'h10, 1'b0, e_data(8'h10, 1'b1));
    push(1'b0, 1'b1, 8'h20, 1'b0, e_data(8'h20, 1'b1));
    push(1'b1, 1'b1, 8'h30, 1'b0, e_idle());
    add_pre(8'h77, 1'b1);
    push(1'b0, 1'b1, 8'h77, 1'b1, e_data(8'h77, 1'b0));
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 8'h00, 1'b0, e_trail(8'hFF, 1'b0));
    add_exit_idle(1'b0, 8'h00, 1'b0);

    foreach (vecs[k]) begin
      rst               = vecs[k].rst;
      tx_bus.tx_valid_i = vecs[k].valid;
      tx_bus.tx_data_i  = vecs[k].data;
      tx_bus.tx_last_i  = vecs[k].last;
      tick();
      act = {tx_bus.tx_ready_o, tx_bus.hs_data_o, tx_bus.hs_oe_o, tx_bus.lp_p_o,
             tx_bus.lp_n_o, tx_bus.busy_o, tx_bus.underrun_o};
      check("vec", k, {2'b00, act}, {2'b00, vecs[k].exp});
    end
    rst               = 1'b0;
    tx_bus.tx_valid_i = 1'b0;

    // Full single-byte burst is busy for 26 cycles with no underrun
    run_burst(8'h5A, 1'b1, bc, uc, to);
    check("burst_timeout", 0, {15'd0, to}, 16'd0);
    check("busy_cycles", 0, bc[15:0], 16'd26);
    check("underrun_cycles", 0, uc[15:0], 16'd0);

    // Starved burst: one underrun pulse, same overall length
    run_burst(8'h11, 1'b0, bc, uc, to);
    check("burst_timeout", 1, {15'd0, to}, 16'd0);
    check("busy_cycles", 1, bc[15:0], 16'd26);
    check("underrun_cycles", 1, uc[15:0], 16'd1);

`ifdef XIL_7S_DPHY_TX_STATS_EN
    // 0x77 burst after the reset plus the two bursts above
    check("burst_cnt", 0, tx_bus.burst_cnt_o, 16'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xil_7s_dphy_hs_data_tx_ctrl.md
Name: xil_7s_dphy_hs_data_tx_ctrl

Overview:
Byte-clock-domain transmit sequencer for one MIPI D-PHY data lane, the transmit-side counterpart of the lane deserializer. Accepts a packet of bytes over a valid/ready stream and drives the full burst: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync 0xB8 -> payload -> HS-trail -> LP-11. Feeds an 8:1 output serializer (hs_data_o) and LP/HS driver enables in the lane IO wrapper.

Parameters:
LPX_CYCLES, 4, LP-01 duration in byte clocks
HS_PREPARE_CYCLES, 2, LP-00 duration before HS driver enable
HS_ZERO_CYCLES, 8, HS-zero bytes (0x00) before sync
HS_TRAIL_CYCLES, 4, HS-trail bytes after last payload byte
HS_EXIT_CYCLES, 6, LP-11 hold after trail before next burst
(A value of 0 for any *_CYCLES parameter is treated as 1. Counter width = $clog2(max parameter + 1).)

Ports:
byte_clk_i  in  1  byte clock; sole clock
rst_i  in  1  synchronous, active-high reset
tx_data_i  in  8  payload byte, bit 0 transmitted first
tx_valid_i  in  1  payload byte valid
tx_last_i  in  1  marks final byte of packet; sampled only on handshake
tx_ready_o  out  1  payload byte accepted when tx_valid_i & tx_ready_o
hs_data_o  out  8  byte to serializer
hs_oe_o  out  1  HS driver enable
lp_p_o  out  1  LP driver, P line
lp_n_o  out  1  LP driver, N line
busy_o  out  1  high in every state except IDLE
underrun_o  out  1  one-cycle pulse on payload starvation

Behaviour:
- One clock (byte_clk_i); reset rst_i is synchronous and active-high.
- All outputs except tx_ready_o are registered, updating on the same edge as the state register. tx_ready_o is decoded from registered state.
- Reset values: state IDLE, hs_data_o 0x00, hs_oe_o 0, lp_p_o/lp_n_o 1/1, tx_ready_o 0, busy_o 0, underrun_o 0.
- Reset asserted mid-burst has the same effect: next edge gives IDLE/LP-11. HS output stops immediately with no trail. The partially sent packet is dropped.
- States and outputs (lp_p/lp_n, hs_oe, hs_data):
  - IDLE: 1/1, 0, 0x00. Exit to LP_RQST when tx_valid_i=1. IDLE lasts at least 1 cycle after HS_EXIT.
  - LP_RQST: 0/1, 0. Lasts LPX_CYCLES, then LP_BRDG.
  - LP_BRDG: 0/0, 0. Lasts HS_PREPARE_CYCLES, then HS_ZERO.
  - HS_ZERO: 0/0, 1, 0x00. Lasts HS_ZERO_CYCLES, then HS_SYNC.
  - HS_SYNC: hs_oe 1, hs_data 0xB8, 1 cycle; tx_ready_o=1.
  - HS_DATA: hs_oe 1, hs_data = most recently accepted byte.
    - tx_ready_o=1 except in the cycle that shows the tx_last_i byte.
    - A byte accepted at edge N is shown during cycle N+1.
  - HS_TRAIL: hs_oe 1, hs_data = {8{~b7}}, where b7 is bit 7 of the last displayed payload byte. Lasts HS_TRAIL_CYCLES.
  - HS_EXIT: 1/1, 0, 0x00. Lasts HS_EXIT_CYCLES, then IDLE.
- Leaving HS_DATA:
  - The cycle after the tx_last_i byte is displayed, enter HS_TRAIL.
  - Underrun: tx_ready_o=1 and tx_valid_i=0 in a HS_SYNC/HS_DATA cycle. The next cycle enters HS_TRAIL and underrun_o pulses for 1 cycle.
  - Underrun in HS_SYNC: b7 is taken as bit 7 of 0xB8, so the trail is 0x00.
- Remaining source bytes after an underrun form a new burst.
- tx_valid_i is ignored outside IDLE-exit and ready cycles. Data is held by the source and is never dropped without a handshake.

Optional Feature:
XIL_7S_DPHY_TX_STATS_EN
- Defined: adds output burst_cnt_o [15:0]. Reset value 0. Increments by 1 on each HS_EXIT->IDLE transition and wraps 0xFFFF->0x0000. It also counts underrun-terminated bursts.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single byte 0x5A with tx_last_i=1, valid asserted in IDLE (defaults) -> LP-01 4 cycles, LP-00 2, hs_oe=1 with 0x00 for 8, 0xB8 for 1, 0x5A for 1, 0xFF for 4, LP-11 with busy for 6, then IDLE. Total busy = 26 cycles.
- Burst 0x01,0x02,0x03,0x84 back-to-back -> hs_data sequence B8,01,02,03,84 on consecutive cycles, tx_ready_o low during the 0x84 cycle, trail 0x00 x4.
- Underrun: 0x11, then valid=0 for 1 cycle -> 0x11 displayed, trail 0xFF x4, underrun_o=1 for exactly 1 cycle; then resend 0x22 (last) -> new full burst starting with LP-01.
- rst_i=1 for 1 cycle while displaying payload byte 2 of 4 -> next cycle hs_oe_o=0, lp=1/1, busy_o=0, tx_ready_o=0. Then valid starts a clean burst with 8 zero bytes + 0xB8.
- tx_valid_i held high through HS_EXIT for a second packet -> tx_ready_o=0 during exit, 1 IDLE cycle, then LP-01 begins. No byte is accepted before its HS_SYNC cycle.
- With XIL_7S_DPHY_TX_STATS_EN: 3 bursts (one underrun-terminated) -> burst_cnt_o=3. Preload via 65535 bursts -> wraps to 0.
